sgt_rr_scheduler: RTL and testbench

SGT_RR_SCHEDULER -- requirements
Module: sgt_rr_scheduler

---
 rtl/sgt_rr_scheduler_if.sv | 27 ++
 rtl/sgt_rr_scheduler.sv | 84 ++++++++
 tb/tb_sgt_rr_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sgt_rr_scheduler_if.sv
// Requester/consumer bundle for the round-robin signed-compare scheduler.
interface sgt_rr_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] in0;
  logic [NREQ*WIDTH-1:0] in1;
  logic [NREQ-1:0]       grant;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out;
  logic [IDW-1:0]        out_id;

  // Requesters and consumer side
  modport master (
    output req, in0, in1, out_ready,
    input  grant, out_valid, out, out_id
  );

  // Scheduler side
  modport slave (
    input  req, in0, in1, out_ready,
    output grant, out_valid, out, out_id
  );
endinterface

// File: rtl/sgt_rr_scheduler.sv
// Round-robin scheduler sharing one signed greater-than comparator among
// NREQ requesters, with a single-entry registered result slot.
module sgt_rr_scheduler #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  sgt_rr_scheduler_if.slave bus
);

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   sel;
  logic             found;
  logic             slot_free;
  logic             issue;
  logic [NREQ-1:0]  grant;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cmp;
  logic             out_valid;
  logic             out_q;
  logic [IDW-1:0]   out_id;
  int               idx;

  assign slot_free = !out_valid || bus.out_ready;

  // Rotating priority search starting at ptr; grant suppressed while resetting
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    grant = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + int'(k)) % NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        sel   = IDW'(idx);
      end
    end
    if (found && slot_free && !RESET)
      grant[sel] = 1'b1;
  end

  assign issue = |grant;

  // Operand mux feeding the single shared comparator
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (sel == IDW'(i)) begin
        op_a = bus.in0[i*WIDTH +: WIDTH];
        op_b = bus.in1[i*WIDTH +: WIDTH];
      end
    end
  end

  assign cmp = $signed(op_a) > $signed(op_b);

  // Result slot and round-robin pointer update
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr       <= '0;
      out_valid <= 1'b0;
      out_q     <= 1'b0;
      out_id    <= '0;
    end else if (issue) begin
      out_q     <= cmp;
      out_id    <= sel;
      out_valid <= 1'b1;
      ptr       <= (sel == IDW'(NREQ - 1)) ? '0 : sel + 1'b1;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.grant     = grant;
  assign bus.out_valid = out_valid;
  assign bus.out       = out_q;
  assign bus.out_id    = out_id;

endmodule

// File: tb/tb_sgt_rr_scheduler.sv
// Self-checking bench for sgt_rr_scheduler (WIDTH=8, NREQ=4): directed
// vector table followed by randomized traffic against a reference model.
module tb_sgt_rr_scheduler;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic clk;
  logic rst;

  sgt_rr_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

  sgt_rr_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        rdy;
    logic [3:0]  grant;
    logic        chk_state;
    logic        ov;
    logic        o;
    logic [1:0]  id;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic row(input logic r, input logic [3:0] req, input logic [31:0] a,
                     input logic [31:0] b, input logic rdy, input logic [3:0] g,
                     input logic cs, input logic ov, input logic o, input logic [1:0] id);
    vec_t v;
    v.rst = r; v.req = req; v.in0 = a; v.in1 = b; v.rdy = rdy; v.grant = g;
    v.chk_state = cs; v.ov = ov; v.o = o; v.id = id;
    vecs.push_back(v);
  endtask

  // Reference model state
  int m_ptr, m_ov, m_out, m_id;

  function automatic int sx(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  initial begin : main
    logic [31:0] rr0, rr1;
    int exp_g, best_d, d, ai, bi;
    logic r, rdy;
    logic [3:0] req;
    logic [31:0] a, b;

    rr0 = 32'h1080FF01;
    rr1 = 32'h107FFE00;
    // rst req  in0           in1           rdy grant  cs ov o id
    row(1, 4'b0000, 32'h0, 32'h0, 1, 4'b0000, 0, 0, 0, 2'd0);
    row(0, 4'b0000, 32'h0, 32'h0, 1, 4'b0000, 1, 0, 0, 2'd0);
    row(0, 4'b0001, 32'h7F, 32'h80, 1, 4'b0001, 1, 0, 0, 2'd0);
    row(0, 4'b0001, 32'h80, 32'h7F, 1, 4'b0001, 1, 1, 1, 2'd0);
    row(0, 4'b0001, 32'h05, 32'h05, 1, 4'b0001, 1, 1, 0, 2'd0);
    row(0, 4'b0000, 32'h0, 32'h0, 1, 4'b0000, 1, 1, 0, 2'd0);
    row(0, 4'b0000, 32'h0, 32'h0, 1, 4'b0000, 1, 0, 0, 2'd0);
    row(1, 4'b1111, rr0, rr1, 1, 4'b0000, 1, 0, 0, 2'd0);
    row(0, 4'b1111, rr0, rr1, 1, 4'b0001, 1, 0, 0, 2'd0);
    row(0, 4'b1111, rr0, rr1, 1, 4'b0010, 1, 1, 1, 2'd0);
    row(0, 4'b1111, rr0, rr1, 1, 4'b0100, 1, 1, 1, 2'd1);
    row(0, 4'b1111, rr0, rr1, 1, 4'b1000, 1, 1, 0, 2'd2);
    row(0, 4'b1111, rr0, rr1, 1, 4'b0001, 1, 1, 0, 2'd3);
    row(0, 4'b0110, rr0, rr1, 0, 4'b0000, 1, 1, 1, 2'd0);
    row(0, 4'b0110, rr0, rr1, 0, 4'b0000, 1, 1, 1, 2'd0);
    row(0, 4'b0110, rr0, rr1, 0, 4'b0000, 1, 1, 1, 2'd0);
    row(0, 4'b0110, rr0, rr1, 1, 4'b0010, 1, 1, 1, 2'd0);
    row(0, 4'b0000, rr0, rr1, 1, 4'b0000, 1, 1, 1, 2'd1);
    row(0, 4'b0100, rr0, rr1, 1, 4'b0100, 1, 0, 1, 2'd1);
    row(0, 4'b0101, rr0, rr1, 1, 4'b0001, 1, 1, 0, 2'd2);
    row(0, 4'b0101, rr0, rr1, 1, 4'b0100, 1, 1, 1, 2'd0);
    row(0, 4'b0000, rr0, rr1, 0, 4'b0000, 1, 1, 0, 2'd2);
    row(1, 4'b1000, rr0, rr1, 0, 4'b0000, 1, 1, 0, 2'd2);
    row(0, 4'b1010, rr0, rr1, 1, 4'b0010, 1, 0, 0, 2'd0);
    row(0, 4'b0000, rr0, rr1, 1, 4'b0000, 1, 1, 1, 2'd1);

    rst = 1'b1;
    bus.req = '0; bus.in0 = '0; bus.in1 = '0; bus.out_ready = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      bus.req = vecs[i].req;
      bus.in0 = vecs[i].in0;
      bus.in1 = vecs[i].in1;
      bus.out_ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d.grant", i), int'(bus.grant), int'(vecs[i].grant));
      if (vecs[i].chk_state) begin
        check($sformatf("vec%0d.out_valid", i), int'(bus.out_valid), int'(vecs[i].ov));
        check($sformatf("vec%0d.out", i), int'(bus.out), int'(vecs[i].o));
        check($sformatf("vec%0d.out_id", i), int'(bus.out_id), int'(vecs[i].id));
      end
    end

    // Model state after the final table row's edge: r1 result consumed-free slot
    @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    @(negedge clk);
    m_ptr = 0; m_ov = 0; m_out = 0; m_id = 0;

    for (int c = 0; c < 2000; c++) begin
      r   = ($urandom_range(0, 39) == 0);
      req = 4'($urandom);
      a   = $urandom;
      b   = ($urandom_range(0, 7) == 0) ? a : $urandom;
      rdy = ($urandom_range(0, 3) != 0);
      rst = r; bus.req = req; bus.in0 = a; bus.in1 = b; bus.out_ready = rdy;
      #1;

      // Expected grant: requester closest to m_ptr going upward with wrap
      exp_g = -1;
      best_d = NREQ;
      if (!r && (m_ov == 0 || rdy)) begin
        for (int i = 0; i < NREQ; i++) begin
          d = (i - m_ptr + NREQ) % NREQ;
          if (req[i] && d < best_d) begin
            best_d = d;
            exp_g = i;
          end
        end
      end
      check("rnd.grant", int'(bus.grant), (exp_g < 0) ? 0 : (1 << exp_g));
      check("rnd.out_valid", int'(bus.out_valid), m_ov);
      if (m_ov != 0) begin
        check("rnd.out", int'(bus.out), m_out);
        check("rnd.out_id", int'(bus.out_id), m_id);
      end

      if (r) begin
        m_ptr = 0; m_ov = 0; m_out = 0; m_id = 0;
      end else if (exp_g >= 0) begin
        ai = sx(a[exp_g*8 +: 8]);
        bi = sx(b[exp_g*8 +: 8]);
        m_out = (ai > bi) ? 1 : 0;
        m_id  = exp_g;
        m_ov  = 1;
        m_ptr = (exp_g + 1) % NREQ;
      end else if (rdy) begin
        m_ov = 0;
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
